// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, SCLK divider, multiple
// active-low selects with optional hold across words, and abort.
module spi_master_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned NUM_SS = 4,
    localparam int unsigned SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              msb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              hold_ss,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LEAD  = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_END   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, d_out_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d, hold_q, hold_d;
    logic [NUM_SS-1:0] ss_d;
    logic              busy_d, done_d, mosi_d, sclk_d, adv;

    // Active-low one-hot select; out-of-range indices select nothing.
    function automatic logic [NUM_SS-1:0] decode_ss(input logic [SEL_W-1:0] sel);
        logic [NUM_SS-1:0] v;
        v = '1;
        for (int i = 0; i < int'(NUM_SS); i++)
            if (int'(sel) == i) v[i] = 1'b0;
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] r, input logic b,
                                                   input logic msb);
        return msb ? {r[DATA_W-2:0], b} : {b, r[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] t, input logic msb);
        return msb ? {t[DATA_W-2:0], 1'b0} : {1'b0, t[DATA_W-1:1]};
    endfunction

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        div_d   = div_q;
        sel_d   = sel_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        msb_d   = msb_q;
        hold_d  = hold_q;
        ss_d    = ss_n;
        d_out_d = d_out;
        adv     = (cnt_q == div_q);

        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ss_d    = '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_SETUP;
                        cnt_d   = '0;
                        bit_d   = '0;
                        tx_d    = d_in;
                        div_d   = clk_div;
                        sel_d   = ss_sel;
                        cpol_d  = cpol;
                        cpha_d  = cpha;
                        msb_d   = msb_first;
                        hold_d  = hold_ss;
                        ss_d    = decode_ss(ss_sel);
                    end
                end
                ST_SETUP: begin
                    if (adv) begin
                        state_d = ST_LEAD;
                        if (!cpha_q) rx_d = rx_shift(rx_q, miso, msb_q);
                    end
                end
                ST_LEAD: begin
                    if (adv) begin
                        state_d = ST_TRAIL;
                        if (cpha_q) rx_d = rx_shift(rx_q, miso, msb_q);
                        else if (bit_q != LAST_BIT) tx_d = tx_shift(tx_q, msb_q);
                    end
                end
                ST_TRAIL: begin
                    if (adv) begin
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_END;
                        end else begin
                            state_d = ST_LEAD;
                            bit_d   = bit_q + CNT_W'(1);
                            if (cpha_q) tx_d = tx_shift(tx_q, msb_q);
                            else        rx_d = rx_shift(rx_q, miso, msb_q);
                        end
                    end
                end
                ST_END: begin
                    if (adv) begin
                        state_d = ST_IDLE;
                        if (!hold_q) ss_d = '1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (state_q != ST_IDLE) cnt_d = adv ? '0 : cnt_q + DIV_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_END) && (cnt_d == div_d);
        if (done_d) d_out_d = rx_d;
        mosi_d = msb_d ? tx_d[DATA_W-1] : tx_d[0];
        sclk_d = cpol_d ^ (state_d == ST_LEAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            div_q   <= '0;
            sel_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            msb_q   <= 1'b0;
            hold_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            d_out   <= '0;
            mosi    <= 1'b0;
            sclk    <= 1'b0;
            ss_n    <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            msb_q   <= msb_d;
            hold_q  <= hold_d;
            busy    <= busy_d;
            done    <= done_d;
            d_out   <= d_out_d;
            mosi    <= mosi_d;
            sclk    <= sclk_d;
            ss_n    <= ss_d;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: 8-bit and 16-bit instances, LSB-first
// slave model on ss_n[0], select-hold, abort and reset scenarios.
module tb_spi_master_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0, abort = 1'b0;
    logic        cpol = 1'b0, cpha = 1'b0, msb_first = 1'b1, hold_ss = 1'b0;
    logic [7:0]  clk_div = 8'd1;
    logic [1:0]  ss_sel = 2'd0;
    logic [7:0]  d_in8 = 8'h00;
    logic [15:0] d_in16 = 16'h0000;
    logic        busy8, done8, mosi8, sclk8, miso8;
    logic        busy16, done16, mosi16, sclk16;
    logic [7:0]  d_out8;
    logic [15:0] d_out16;
    logic [3:0]  ss_n8, ss_n16;
    logic        loop8 = 1'b1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(8), .DIV_W(8), .NUM_SS(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort), .busy(busy8), .done(done8),
        .d_in(d_in8), .d_out(d_out8), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
        .clk_div(clk_div), .ss_sel(ss_sel), .hold_ss(hold_ss), .miso(miso8), .mosi(mosi8),
        .sclk(sclk8), .ss_n(ss_n8)
    );

    spi_master_param #(.DATA_W(16), .DIV_W(8), .NUM_SS(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort), .busy(busy16), .done(done16),
        .d_in(d_in16), .d_out(d_out16), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
        .clk_div(clk_div), .ss_sel(ss_sel), .hold_ss(hold_ss), .miso(mosi16), .mosi(mosi16),
        .sclk(sclk16), .ss_n(ss_n16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // LSB-first slave on ss_n8[0]; returns s_word, records what it received in s_rx.
    logic       cur_cpol = 1'b0, cur_cpha = 1'b0;
    logic [7:0] s_word = 8'hC3;
    logic [7:0] s_rx = 8'h00;
    logic       miso_s = 1'b0;
    logic       s_ss_prev = 1'b1, s_sclk_prev = 1'b0;
    int         s_idx = 0;

    assign miso8 = loop8 ? mosi8 : miso_s;

    always @(negedge clk) begin
        if (!ss_n8[0] && s_ss_prev) begin
            s_idx  <= 0;
            miso_s <= s_word[0];
            s_rx   <= 8'h00;
        end else if (!ss_n8[0] && sclk8 != s_sclk_prev) begin
            if (sclk8 != cur_cpol) begin
                if (cur_cpha) begin
                    if (s_idx < 8) begin
                        miso_s <= s_word[s_idx];
                        s_idx  <= s_idx + 1;
                    end
                end else begin
                    s_rx <= {mosi8, s_rx[7:1]};
                end
            end else begin
                if (cur_cpha) s_rx <= {mosi8, s_rx[7:1]};
                else if (s_idx < 7) begin
                    miso_s <= s_word[s_idx+1];
                    s_idx  <= s_idx + 1;
                end
            end
        end
        s_ss_prev   <= ss_n8[0];
        s_sclk_prev <= sclk8;
    end

    // Select-edge monitor for the hold/swap scenario.
    logic [3:0] m_ss_prev = 4'hF;
    int ss2_rise = 0, ss2_swap = 0;
    always @(negedge clk) begin
        if (ss_n8[2] && !m_ss_prev[2]) begin
            ss2_rise <= ss2_rise + 1;
            if (m_ss_prev[1] && !ss_n8[1]) ss2_swap <= ss2_swap + 1;
        end
        m_ss_prev <= ss_n8;
    end

    // One word on dut8; cycle 1 is the cycle after the edge that samples start.
    task automatic xfer8(input logic [7:0] din, input logic cp, input logic ch, input logic msb,
                         input logic [7:0] div, input logic [1:0] sel, input logic hold,
                         output int done_cyc, output int ss_first, output int ss_low,
                         output logic ss_post, output int rises, output logic sclk_pre,
                         output logic sclk_post, output logic busy_done, output logic busy_post);
        int   cyc;
        logic prev;
        @(negedge clk);
        d_in8 = din; cpol = cp; cpha = ch; msb_first = msb; clk_div = div;
        ss_sel = sel; hold_ss = hold; cur_cpol = cp; cur_cpha = ch; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1; done_cyc = -1; ss_first = -1; ss_low = 0; rises = 0;
        ss_post = 1'bx; sclk_post = 1'bx; busy_done = 1'bx; busy_post = 1'bx;
        prev = sclk8; sclk_pre = sclk8;
        while (cyc < 2000) begin
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                ss_post = ss_n8[sel]; sclk_post = sclk8; busy_post = busy8;
                break;
            end
            if (!ss_n8[sel]) begin
                if (ss_first < 0) ss_first = cyc;
                ss_low++;
            end
            if (sclk8 && !prev) rises++;
            prev = sclk8;
            if (done8 && done_cyc < 0) begin
                done_cyc = cyc; busy_done = busy8;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("xfer_done_seen", 32'(done_cyc > 0), 1);
    endtask

    int   dc, sf, sl, rs, r2, cyc, nedge, dcount;
    logic sp, spre, spost, bd, bp, prev, mfirst, s2, s3;

    initial begin
        #23 rst_n = 1'b1;
        check_eq("rst8_outputs", {busy8, done8, d_out8, mosi8, sclk8, ss_n8}, {2'b00, 8'h00, 2'b00, 4'hF});
        check_eq("rst16_outputs", {busy16, done16, d_out16, mosi16, sclk16, ss_n16}, {2'b00, 16'h0, 2'b00, 4'hF});

        // Mode 0 loopback, MSB first.
        loop8 = 1'b1;
        xfer8(8'hA5, 0, 0, 1, 8'd1, 2'd0, 0, dc, sf, sl, sp, rs, spre, spost, bd, bp);
        check_eq("m0_done_cyc", dc, 36);
        check_eq("m0_dout", 32'(d_out8), 32'h A5);
        check_eq("m0_rises", rs, 8);
        check_eq("m0_ss_first", sf, 1);
        check_eq("m0_ss_low_cycles", sl, 36);
        check_eq("m0_ss_released", 32'(sp), 1);
        check_eq("m0_busy_at_done", 32'(bd), 1);
        check_eq("m0_busy_after", 32'(bp), 0);

        // All four modes, LSB first, against the slave model.
        loop8 = 1'b0;
        for (int m = 0; m < 4; m++) begin
            xfer8(8'h3C, m[1], m[0], 0, 8'd1, 2'd0, 0, dc, sf, sl, sp, rs, spre, spost, bd, bp);
            check_eq($sformatf("mode%0d_dout", m), 32'(d_out8), 32'hC3);
            check_eq($sformatf("mode%0d_slave_rx", m), 32'(s_rx), 32'h3C);
            check_eq($sformatf("mode%0d_sclk_setup", m), 32'(spre), 32'(m[1]));
            check_eq($sformatf("mode%0d_sclk_after", m), 32'(spost), 32'(m[1]));
            check_eq($sformatf("mode%0d_done_cyc", m), dc, 36);
        end

        // Abort at the 5th sclk edge.
        @(negedge clk);
        d_in8 = 8'h5A; cpol = 0; cpha = 0; msb_first = 1; clk_div = 8'd1;
        ss_sel = 2'd0; hold_ss = 0; cur_cpol = 0; cur_cpha = 0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        nedge = 0; prev = sclk8;
        for (int i = 0; i < 200 && nedge < 5; i++) begin
            @(negedge clk);
            if (sclk8 != prev) nedge++;
            prev = sclk8;
        end
        check_eq("abort_edge5_seen", nedge, 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy8), 0);
        check_eq("abort_ss_n", 32'(ss_n8), 32'hF);
        check_eq("abort_sclk", 32'(sclk8), 0);
        check_eq("abort_dout_kept", 32'(d_out8), 32'hC3);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done8) dcount++;
        end
        check_eq("abort_no_done", dcount, 0);

        // Select hold on slave 2, then swap to slave 1.
        r2 = ss2_rise;
        xfer8(8'h11, 0, 0, 1, 8'd1, 2'd2, 1, dc, sf, sl, sp, rs, spre, spost, bd, bp);
        check_eq("hold1_ss_kept", 32'(sp), 0);
        xfer8(8'h22, 0, 0, 1, 8'd1, 2'd2, 1, dc, sf, sl, sp, rs, spre, spost, bd, bp);
        check_eq("hold2_done_cyc", dc, 36);
        check_eq("hold2_ss_kept", 32'(sp), 0);
        check_eq("hold_no_ss2_rise", ss2_rise - r2, 0);
        xfer8(8'h33, 0, 0, 1, 8'd1, 2'd1, 0, dc, sf, sl, sp, rs, spre, spost, bd, bp);
        check_eq("swap_ss1_first", sf, 1);
        check_eq("swap_same_cycle", ss2_swap, 1);
        check_eq("swap_ss2_rise", ss2_rise - r2, 1);

        // Abort in IDLE releases a held select.
        xfer8(8'h44, 0, 0, 1, 8'd1, 2'd3, 1, dc, sf, sl, sp, rs, spre, spost, bd, bp);
        check_eq("hold3_ss_kept", 32'(sp), 0);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check_eq("idle_abort_release", 32'(ss_n8), 32'hF);

        // 16-bit word, divider 0, loopback.
        @(negedge clk);
        d_in16 = 16'h8001; cpol = 0; cpha = 0; msb_first = 1; clk_div = 8'd0;
        ss_sel = 2'd0; hold_ss = 0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        cyc = 1; dc = -1; rs = 0; prev = sclk16; mfirst = mosi16; s2 = 1'bx; s3 = 1'bx;
        while (cyc < 200 && dc < 0) begin
            if (cyc == 2) s2 = sclk16;
            if (cyc == 3) s3 = sclk16;
            if (sclk16 && !prev) rs++;
            prev = sclk16;
            if (done16) dc = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check_eq("w16_done_cyc", dc, 34);
        check_eq("w16_mosi_first", 32'(mfirst), 1);
        check_eq("w16_sclk_c2", 32'(s2), 1);
        check_eq("w16_sclk_c3", 32'(s3), 0);
        check_eq("w16_rises", rs, 16);
        check_eq("w16_dout", 32'(d_out16), 32'h8001);

        // Asynchronous reset mid-transfer.
        @(negedge clk);
        d_in8 = 8'hFF; clk_div = 8'd1; ss_sel = 2'd0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_outputs", {busy8, done8, d_out8, mosi8, sclk8, ss_n8}, {2'b00, 8'h00, 2'b00, 4'hF});
        @(negedge clk); rst_n = 1'b1;

        // start and abort together: no transfer.
        @(negedge clk);
        start8 = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", 32'(busy8), 0);
        check_eq("start_abort_ss_n", 32'(ss_n8), 32'hF);
        repeat (5) @(posedge clk);
        #1;
        check_eq("start_abort_busy_later", 32'(busy8), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
